axis_mt19937_check: RTL and testbench

AXI4-Stream sink that consumes 32-bit words produced by an MT19937 generator, reconstructs the generator's 624-word state by untempering the first 624 words, then predicts every following word and flags any mismatch. It sits at the receive end of an MT19937 stream as a built-in checker. Typical uses are link and data-path integrity testing, and verifying the generator block in hardware.

---
 rtl/mt19937_pkg.sv | 40 ++++
 rtl/mt19937_state_ram.sv | 25 ++
 rtl/axis_mt19937_check.sv | 139 +++++++++++++
 tb/tb_axis_mt19937_check.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mt19937_pkg.sv
// rtl/mt19937_pkg.sv - MT19937 constants, checker state enum, temper/untemper helpers.
package mt19937_pkg;

  localparam int N = 624;
  localparam int M = 397;
  localparam logic [31:0] MATRIX_A = 32'h9908b0df;
  localparam logic [31:0] TEMPER_B = 32'h9d2c5680;
  localparam logic [31:0] TEMPER_C = 32'hefc60000;

  typedef enum logic [1:0] {IDLE, FILL, PRIME, CHECK} state_e;

  function automatic logic [31:0] temper(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x >> 11);
    y = y ^ ((y << 7) & TEMPER_B);
    y = y ^ ((y << 15) & TEMPER_C);
    y = y ^ (y >> 18);
    return y;
  endfunction

  // Each shift-xor step is inverted in reverse order; the <<7 step needs
  // four passes to rebuild all 32 bits seven at a time.
  function automatic logic [31:0] untemper(input logic [31:0] x);
    logic [31:0] y;
    logic [31:0] z;
    y = x ^ (x >> 18);
    y = y ^ ((y << 15) & TEMPER_C);
    z = y;
    for (int i = 0; i < 4; i++) begin
      z = y ^ ((z << 7) & TEMPER_B);
    end
    y = z ^ (z >> 11) ^ (z >> 22);
    return y;
  endfunction

  function automatic logic [9:0] ptr_inc(input logic [9:0] p);
    return (p == 10'(N - 1)) ? 10'd0 : p + 10'd1;
  endfunction

endpackage

// File: rtl/mt19937_state_ram.sv
// rtl/mt19937_state_ram.sv - 624x32 state memory, one write port, two registered read ports.
module mt19937_state_ram
  import mt19937_pkg::*;
(
  input  logic        clk,
  input  logic        we_i,
  input  logic [9:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [9:0]  raddr_a_i,
  input  logic [9:0]  raddr_b_i,
  output logic [31:0] rdata_a_o,
  output logic [31:0] rdata_b_o
);

  logic [31:0] mem_q [N];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_a_o <= mem_q[raddr_a_i];
    rdata_b_o <= mem_q[raddr_b_i];
  end

endmodule

// File: rtl/axis_mt19937_check.sv
// rtl/axis_mt19937_check.sv - AXI-Stream MT19937 checker: untemper 624 words, then predict and compare.
// Optional saturating mismatch_count port with AXIS_MT19937_CHECK_COUNT_EN.
module axis_mt19937_check
  import mt19937_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_axis_tdata,
  input  logic        input_axis_tvalid,
  output logic        input_axis_tready,
  input  logic        clear,
  output logic        locked,
  output logic        mismatch
`ifdef AXIS_MT19937_CHECK_COUNT_EN
  ,
  output logic [15:0] mismatch_count
`endif
);

  state_e      state_q, state_d;
  logic [9:0]  idx_q, idx_d;
  logic [9:0]  a_ptr_q, a_ptr_d;
  logic [9:0]  b_ptr_q, b_ptr_d;
  logic [31:0] save_q, save_d;
  logic        mismatch_q, mismatch_d;

  logic        we;
  logic [31:0] wdata;
  logic [31:0] rd_a, rd_b;
  logic [31:0] y, twist;
  logic        beat, hit_error;

  mt19937_state_ram u_ram (
    .clk       (clk),
    .we_i      (we),
    .waddr_i   (idx_q),
    .wdata_i   (wdata),
    .raddr_a_i (a_ptr_d),
    .raddr_b_i (b_ptr_d),
    .rdata_a_o (rd_a),
    .rdata_b_o (rd_b)
  );

  // clear gates tready so a coincident beat is never handshaken.
  assign input_axis_tready = ((state_q == FILL) || (state_q == CHECK)) && !clear;
  assign locked            = (state_q == CHECK);
  assign mismatch          = mismatch_q;
  assign beat              = input_axis_tvalid && input_axis_tready;

  assign y         = {save_q[31], rd_a[30:0]};
  assign twist     = rd_b ^ (y >> 1) ^ (y[0] ? MATRIX_A : 32'h0);
  assign hit_error = (temper(twist) != input_axis_tdata);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    a_ptr_d    = a_ptr_q;
    b_ptr_d    = b_ptr_q;
    save_d     = save_q;
    mismatch_d = mismatch_q;
    we         = 1'b0;
    wdata      = untemper(input_axis_tdata);
    case (state_q)
      IDLE: state_d = FILL;
      FILL: begin
        a_ptr_d = '0;
        if (beat) begin
          we    = 1'b1;
          idx_d = idx_q + 10'd1;
          if (idx_q == 10'(N - 1)) state_d = PRIME;
        end
      end
      PRIME: begin
        save_d  = rd_a;
        a_ptr_d = 10'd1;
        b_ptr_d = 10'(M);
        idx_d   = '0;
        state_d = CHECK;
      end
      CHECK: begin
        if (beat) begin
          we      = 1'b1;
          wdata   = twist;
          save_d  = rd_a;
          idx_d   = ptr_inc(idx_q);
          a_ptr_d = ptr_inc(a_ptr_q);
          b_ptr_d = ptr_inc(b_ptr_q);
          if (hit_error) mismatch_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d    = IDLE;
      idx_d      = '0;
      mismatch_d = 1'b0;
      we         = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      a_ptr_q    <= '0;
      b_ptr_q    <= '0;
      save_q     <= '0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      a_ptr_q    <= a_ptr_d;
      b_ptr_q    <= b_ptr_d;
      save_q     <= save_d;
      mismatch_q <= mismatch_d;
    end
  end

`ifdef AXIS_MT19937_CHECK_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if ((state_q == CHECK) && beat && hit_error && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign mismatch_count = cnt_q;
`endif

endmodule

// File: tb/tb_axis_mt19937_check.sv
// tb/tb_axis_mt19937_check.sv - scoreboard bench for axis_mt19937_check against a software MT19937.
// Set AXIS_MT19937_CHECK_COUNT_EN to also exercise mismatch_count.
module tb_axis_mt19937_check;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        tvalid = 1'b0;
  logic [31:0] tdata = '0;
  logic        tready;
  logic        locked;
  logic        mismatch;
`ifdef AXIS_MT19937_CHECK_COUNT_EN
  logic [15:0] mcount;
`endif

  always #5 clk = ~clk;

  axis_mt19937_check dut (
    .clk               (clk),
    .rst               (rst),
    .input_axis_tdata  (tdata),
    .input_axis_tvalid (tvalid),
    .input_axis_tready (tready),
    .clear             (clear),
    .locked            (locked),
    .mismatch          (mismatch)
`ifdef AXIS_MT19937_CHECK_COUNT_EN
    ,
    .mismatch_count    (mcount)
`endif
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit lk;
    bit mm;
    int cnt;
    int beat;
  } exp_t;
  exp_t sb_q[$];

  bit [31:0] g_mt [624];
  int        g_idx;
  int        s_beats;
  int        s_errs;
  bit        s_mm;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit [31:0] tb_temper(input bit [31:0] v);
    bit [31:0] r;
    r = v ^ (v >> 11);
    r = r ^ ((r << 7) & 32'h9d2c5680);
    r = r ^ ((r << 15) & 32'hefc60000);
    r = r ^ (r >> 18);
    return r;
  endfunction

  task automatic gen_init(input bit [31:0] seed);
    g_mt[0] = seed;
    for (int i = 1; i < 624; i++)
      g_mt[i] = 32'd1812433253 * (g_mt[i-1] ^ (g_mt[i-1] >> 30)) + 32'(i);
    g_idx = 624;
  endtask

  function automatic bit [31:0] gen_next();
    bit [31:0] v;
    if (g_idx >= 624) begin
      for (int k = 0; k < 624; k++) begin
        v = (g_mt[k] & 32'h80000000) | (g_mt[(k + 1) % 624] & 32'h7fffffff);
        g_mt[k] = g_mt[(k + 397) % 624] ^ (v >> 1) ^ (v[0] ? 32'h9908b0df : 32'h0);
      end
      g_idx = 0;
    end
    v = g_mt[g_idx];
    g_idx++;
    return tb_temper(v);
  endfunction

  task automatic sess_reset();
    s_beats = 0;
    s_errs  = 0;
    s_mm    = 1'b0;
  endtask

  always begin : monitor
    bit   hs;
    exp_t e;
    @(posedge clk);
    hs = tvalid && tready;
    @(negedge clk);
    if (hs) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_beat: beat accepted with no expectation at %0t", $time);
      end else begin
        e = sb_q.pop_front();
        chk($sformatf("beat%0d_locked", e.beat), locked, e.lk);
        chk($sformatf("beat%0d_mismatch", e.beat), mismatch, e.mm);
`ifdef AXIS_MT19937_CHECK_COUNT_EN
        chk($sformatf("beat%0d_count", e.beat), mcount, e.cnt);
`endif
      end
    end
  end

  task automatic drive(input bit [31:0] w, input bit [31:0] ideal, input int gap_pct);
    exp_t e;
    int   n;
    if (gap_pct > 0) begin
      while ($urandom_range(99) < gap_pct) begin
        tvalid = 1'b0;
        @(negedge clk);
      end
    end
    tvalid = 1'b1;
    tdata  = w;
    n = 0;
    while (!tready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!tready) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout: tready stayed 0 for beat %0d", s_beats + 1);
      tvalid = 1'b0;
      return;
    end
    s_beats++;
    if (s_beats > 624 && w != ideal) begin
      s_mm = 1'b1;
      if (s_errs < 65535) s_errs++;
    end
    e.lk   = (s_beats > 624);
    e.mm   = s_mm;
    e.cnt  = s_errs;
    e.beat = s_beats;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic stream(input int n, input int corrupt_at, input bit corrupt_locked, input int gap_pct);
    bit [31:0] ideal;
    bit [31:0] w;
    for (int i = 0; i < n; i++) begin
      ideal = gen_next();
      w = ideal;
      if (s_beats + 1 == corrupt_at) w = w ^ 32'h1;
      if (corrupt_locked && s_beats >= 624) w = w ^ 32'h1;
      drive(w, ideal, gap_pct);
    end
    tvalid = 1'b0;
  endtask

  task automatic do_reset();
    tvalid = 1'b0;
    clear  = 1'b0;
    rst    = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sess_reset();
  endtask

  initial begin
    #1_200_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    sess_reset();
    repeat (3) @(negedge clk);
    chk("reset_tready", tready, 0);
    chk("reset_locked", locked, 0);
    chk("reset_mismatch", mismatch, 0);
`ifdef AXIS_MT19937_CHECK_COUNT_EN
    chk("reset_count", mcount, 0);
`endif
    rst = 1'b0;
    chk("idle_tready", tready, 0);
    @(negedge clk);
    chk("first_tready", tready, 1);

    // Clean seed-5489 stream, lock point checked explicitly.
    gen_init(32'd5489);
    stream(624, 0, 1'b0, 0);
    chk("prime_tready", tready, 0);
    chk("prime_locked", locked, 0);
    @(negedge clk);
    chk("lock_locked", locked, 1);
    chk("lock_tready", tready, 1);
    stream(2000, 0, 1'b0, 0);
    chk("clean_mismatch", mismatch, 0);

    // Single corrupted word at beat 700.
    do_reset();
    gen_init(32'd5489);
    stream(1500, 700, 1'b0, 0);
    chk("corrupt_mismatch", mismatch, 1);
`ifdef AXIS_MT19937_CHECK_COUNT_EN
    chk("corrupt_count", mcount, 1);
`endif

    // Random tvalid gaps.
    do_reset();
    gen_init($urandom);
    stream(624, 0, 1'b0, 30);
    chk("gap_prime_tready", tready, 0);
    chk("gap_prime_locked", locked, 0);
    stream(876, 0, 1'b0, 30);
    chk("gap_locked", locked, 1);
    chk("gap_mismatch", mismatch, 0);

    // clear together with a valid beat 800, then reseed.
    do_reset();
    gen_init(32'd5489);
    stream(799, 700, 1'b0, 0);
    chk("pre_clear_mismatch", mismatch, 1);
    tdata  = gen_next();
    tvalid = 1'b1;
    clear  = 1'b1;
    #1;
    chk("clear_tready", tready, 0);
    @(negedge clk);
    clear  = 1'b0;
    tvalid = 1'b0;
    chk("clear_locked", locked, 0);
    chk("clear_mismatch", mismatch, 0);
`ifdef AXIS_MT19937_CHECK_COUNT_EN
    chk("clear_count", mcount, 0);
`endif
    sess_reset();
    gen_init(32'd1);
    stream(1624, 0, 1'b0, 0);
    chk("reseed_locked", locked, 1);
    chk("reseed_mismatch", mismatch, 0);

    // Asynchronous reset mid-FILL and mid-CHECK.
    do_reset();
    gen_init(32'd5489);
    stream(300, 0, 1'b0, 0);
    #2 rst = 1'b1;
    #1;
    chk("async_fill_tready", tready, 0);
    chk("async_fill_locked", locked, 0);
    @(negedge clk);
    rst = 1'b0;
    sess_reset();
    gen_init(32'd5489);
    stream(1624, 0, 1'b0, 0);
    chk("restream_locked", locked, 1);
    chk("restream_mismatch", mismatch, 0);
    #2 rst = 1'b1;
    #1;
    chk("async_check_locked", locked, 0);
    chk("async_check_tready", tready, 0);
    @(negedge clk);
    rst = 1'b0;
    sess_reset();

`ifdef AXIS_MT19937_CHECK_COUNT_EN
    // Counter saturation.
    do_reset();
    gen_init(32'd42);
    stream(624 + 70000, 0, 1'b1, 0);
    chk("sat_count", mcount, 16'hFFFF);
    chk("sat_mismatch", mismatch, 1);
`endif

    @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
